// File: rtl/shared_pkg.sv
// Shared definitions for the APB request arbiter: FSM state encoding and
// the number of WAIT cycles during which a done indication is not trusted.
package shared_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_RESP
  } apb_arb_state_e;

  // PREADY left over from the master's IDLE/SETUP phases shows up in these cycles
  localparam int unsigned APB_ARB_DONE_MASK = 2;

endpackage

// File: rtl/apb_rr_pick.sv
// Round-robin selector: rotate the request vector by the pointer, take the
// lowest set bit, then rotate the index back into requester numbering.
module apb_rr_pick #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IDX_W-1:0]  off;
  logic [IDX_W:0]    sum;

  always_comb begin
    dbl = {req_valid, req_valid} >> rr_ptr;
    rot = dbl[NREQ-1:0];
    off = '0;
    // descending scan so the lowest set bit is written last
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(NREQ)) sum = sum - (IDX_W+1)'(NREQ);
  end

  assign any = |req_valid;
  assign idx = sum[IDX_W-1:0];

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master controller between NREQ requesters: round-robin
// accept, single outstanding transaction, response return and WAIT timeout.
module apb_req_arbiter
  import shared_pkg::*;
#(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NBYTES     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic [NREQ-1:0]                  req_valid,
  output logic [NREQ-1:0]                  req_ready,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NREQ-1:0]                  req_write,
  input  logic [NREQ-1:0][NBYTES-1:0]      req_strb,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]  req_wdata,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic [ADDR_WIDTH-1:0]            m_addr,
  output logic                             m_write,
  output logic [NBYTES-1:0]                m_byte_strobe,
  output logic [DATA_WIDTH-1:0]            m_wdata,
  output logic                             m_transfer,
  input  logic [DATA_WIDTH-1:0]            m_rdata,
  input  logic                             m_transfer_done
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  apb_arb_state_e state, state_nxt;

  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      owner;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic [CNT_W-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] rd_shadow;

  logic [ADDR_WIDTH-1:0] txn_addr;
  logic                  txn_write;
  logic [NBYTES-1:0]     txn_strb;
  logic [DATA_WIDTH-1:0] txn_wdata;

  logic accept;
  logic done_hit;
  logic timeout_hit;

  apb_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .any       (pick_any),
    .idx       (pick_idx)
  );

  // Next-state and state-decoded strobes
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    req_ready   = '0;
    m_transfer  = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          accept    = 1'b1;
          req_ready = NREQ'(1) << pick_idx;
          state_nxt = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        m_transfer = 1'b1;
        state_nxt  = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (m_transfer_done && (wait_cnt >= CNT_W'(APB_ARB_DONE_MASK))) begin
          done_hit  = 1'b1;
          state_nxt = ARB_RESP;
        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_nxt   = ARB_RESP;
        end
      end
      ARB_RESP: begin
        state_nxt = ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  // Transaction registers: loaded on accept, cleared on the way back to idle
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      owner     <= '0;
      txn_addr  <= '0;
      txn_write <= 1'b0;
      txn_strb  <= '0;
      txn_wdata <= '0;
    end else if (accept) begin
      owner     <= pick_idx;
      txn_addr  <= req_addr[pick_idx];
      txn_write <= req_write[pick_idx];
      txn_strb  <= req_strb[pick_idx];
      txn_wdata <= req_wdata[pick_idx];
    end else if (state == ARB_RESP) begin
      txn_addr  <= '0;
      txn_write <= 1'b0;
      txn_strb  <= '0;
      txn_wdata <= '0;
    end
  end

  // WAIT-phase counter and one-cycle-delayed read data
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wait_cnt  <= '0;
      rd_shadow <= '0;
    end else begin
      if (state == ARB_ISSUE)     wait_cnt <= '0;
      else if (state == ARB_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == ARB_WAIT)      rd_shadow <= m_rdata;
    end
  end

  // Response registers and round-robin pointer
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rr_ptr    <= '0;
    end else begin
      rsp_valid <= '0;
      if (done_hit) begin
        rsp_valid <= NREQ'(1) << owner;
        rsp_rdata <= txn_write ? '0 : rd_shadow;
        rsp_err   <= 1'b0;
      end else if (timeout_hit) begin
        rsp_valid <= NREQ'(1) << owner;
        rsp_rdata <= '0;
        rsp_err   <= 1'b1;
      end
      if (state == ARB_RESP) begin
        rr_ptr <= (owner == IDX_W'(NREQ - 1)) ? '0 : owner + IDX_W'(1);
      end
    end
  end

  assign m_addr        = txn_addr;
  assign m_write       = txn_write;
  assign m_byte_strobe = txn_strb;
  assign m_wdata       = txn_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed and randomized bench for apb_req_arbiter; the master/slave pair
// is modelled cycle by cycle relative to each accept.
module tb_apb_req_arbiter;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 32;
  localparam int unsigned NB      = DW / 8;
  localparam int unsigned TIMEOUT = 16;

  logic                    PCLK;
  logic                    PRESETn;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][AW-1:0] req_addr;
  logic [NREQ-1:0]         req_write;
  logic [NREQ-1:0][NB-1:0] req_strb;
  logic [NREQ-1:0][DW-1:0] req_wdata;
  logic [NREQ-1:0]         rsp_valid;
  logic [DW-1:0]           rsp_rdata;
  logic                    rsp_err;
  logic [AW-1:0]           m_addr;
  logic                    m_write;
  logic [NB-1:0]           m_byte_strobe;
  logic [DW-1:0]           m_wdata;
  logic                    m_transfer;
  logic [DW-1:0]           m_rdata;
  logic                    m_transfer_done;

  int n_cmp;
  int n_fail;
  int model_ptr;

  apb_req_arbiter #(
    .NREQ       (NREQ),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NBYTES     (NB),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .PCLK            (PCLK),
    .PRESETn         (PRESETn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_write       (req_write),
    .req_strb        (req_strb),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .m_addr          (m_addr),
    .m_write         (m_write),
    .m_byte_strobe   (m_byte_strobe),
    .m_wdata         (m_wdata),
    .m_transfer      (m_transfer),
    .m_rdata         (m_rdata),
    .m_transfer_done (m_transfer_done)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference arbitration: first requesting index at or after the pointer, cyclically
  function automatic int model_pick(input logic [NREQ-1:0] m, input int ptr);
    for (int k = 0; k < int'(NREQ); k++) begin
      if (m[(ptr + k) % int'(NREQ)]) return (ptr + k) % int'(NREQ);
    end
    return -1;
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < int'(NREQ); i++) begin
      req_addr[i]  = AW'($urandom);
      req_write[i] = 1'($urandom);
      req_strb[i]  = NB'($urandom);
      req_wdata[i] = DW'($urandom);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, req_ready, '0);
    check({tag, "_xfer"}, m_transfer, 1'b0);
    check({tag, "_rspv"}, rsp_valid, '0);
    check({tag, "_addr"}, m_addr, '0);
    check({tag, "_wr"}, m_write, 1'b0);
    check({tag, "_strb"}, m_byte_strobe, '0);
    check({tag, "_wdata"}, m_wdata, '0);
  endtask

  // One full transaction from the accept cycle (r=0) through the response cycle
  task automatic run_txn(input logic [NREQ-1:0] mask, input int waits,
                         input bit stale, input bit hang, input logic [DW-1:0] sdata);
    int owner;
    int rsp_rel;
    bit err;
    logic [AW-1:0] ea;
    logic          ewr;
    logic [NB-1:0] es;
    logic [DW-1:0] ewd;
    logic [DW-1:0] erd;
    @(posedge PCLK); #1;
    req_valid       = mask;
    m_transfer_done = stale;
    m_rdata         = DW'($urandom);
    owner   = model_pick(mask, model_ptr);
    ea      = req_addr[owner];
    ewr     = req_write[owner];
    es      = req_strb[owner];
    ewd     = req_wdata[owner];
    err     = hang || (4 + waits > int'(TIMEOUT) + 1);
    rsp_rel = err ? int'(TIMEOUT) + 2 : 5 + waits;
    erd     = (err || ewr) ? '0 : sdata;
    @(negedge PCLK);
    check("accept_ready", req_ready, oh(owner));
    check("idle_xfer", m_transfer, 1'b0);
    check("idle_addr", m_addr, '0);
    for (int r = 1; r <= rsp_rel; r++) begin
      @(posedge PCLK); #1;
      if (r == 1) begin
        req_addr[owner]  = AW'($urandom);
        req_wdata[owner] = DW'($urandom);
        req_write[owner] = ~req_write[owner];
        req_strb[owner]  = ~req_strb[owner];
      end
      req_valid       = NREQ'($urandom) & ~oh(owner);
      m_transfer_done = (stale && r <= 3) || (!hang && r == 4 + waits);
      m_rdata         = (!hang && r == 3 + waits) ? sdata : DW'($urandom);
      @(negedge PCLK);
      check("m_transfer", m_transfer, r == 1);
      check("busy_ready", req_ready, '0);
      check("m_addr", m_addr, ea);
      check("m_write", m_write, ewr);
      check("m_strb", m_byte_strobe, es);
      check("m_wdata", m_wdata, ewd);
      check("rsp_valid", rsp_valid, (r == rsp_rel) ? oh(owner) : '0);
      if (r == rsp_rel) begin
        check("rsp_err", rsp_err, err);
        check("rsp_rdata", rsp_rdata, erd);
      end
    end
    model_ptr = (owner + 1) % int'(NREQ);
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    model_ptr       = 0;
    PRESETn         = 1'b0;
    req_valid       = '0;
    m_transfer_done = 1'b0;
    m_rdata         = '0;
    randomize_reqs();

    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check_quiet("reset");
    check("reset_rdata", rsp_rdata, '0);
    check("reset_err", rsp_err, 1'b0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    @(posedge PCLK); #1;
    req_valid       = '0;
    m_transfer_done = 1'b1;
    @(negedge PCLK);
    check_quiet("idle");

    // single zero-wait read by requester 0
    req_addr[0] = AW'(32'h10);
    req_write[0] = 1'b0;
    run_txn(2'b01, 0, 1'b0, 1'b0, 32'hCAFEF00D);

    // write with partial strobe by requester 1
    req_addr[1]  = AW'(32'h24);
    req_write[1] = 1'b1;
    req_strb[1]  = NB'(4'b0011);
    req_wdata[1] = DW'(32'hA5A5A5A5);
    run_txn(2'b10, 0, 1'b0, 1'b0, DW'($urandom));

    // both requesting: alternation 0,1,0,1
    for (int t = 0; t < 4; t++) begin
      randomize_reqs();
      run_txn(2'b11, $urandom_range(0, 2), 1'b0, 1'b0, DW'($urandom));
    end

    // slave never ready, then a normal request afterwards
    randomize_reqs();
    req_write[0] = 1'b0;
    run_txn(2'b11, 0, 1'b0, 1'b1, DW'($urandom));
    randomize_reqs();
    run_txn(2'b11, 1, 1'b0, 1'b0, DW'($urandom));

    // stale done during IDLE/SETUP and three wait states
    randomize_reqs();
    req_write[0] = 1'b0;
    req_write[1] = 1'b0;
    run_txn(2'b11, 3, 1'b1, 1'b0, DW'($urandom));

    // done on the last allowed WAIT cycle wins; one cycle later is a timeout
    randomize_reqs();
    req_write[0] = 1'b0;
    req_write[1] = 1'b0;
    run_txn(2'b11, int'(TIMEOUT) - 3, 1'b0, 1'b0, DW'($urandom));
    randomize_reqs();
    req_write[0] = 1'b0;
    req_write[1] = 1'b0;
    run_txn(2'b11, int'(TIMEOUT) - 2, 1'b0, 1'b0, DW'($urandom));

    for (int t = 0; t < 30; t++) begin
      randomize_reqs();
      run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom_range(0, 6),
              1'($urandom), ($urandom_range(0, 9) == 0), DW'($urandom));
    end

    // reset in the middle of WAIT: leave the pointer at 1 first, then abandon a req1 read
    randomize_reqs();
    req_write[0] = 1'b0;
    run_txn(2'b01, 0, 1'b0, 1'b0, 32'h1234_5678);
    @(posedge PCLK); #1;
    req_write[1]    = 1'b0;
    req_valid       = 2'b10;
    m_transfer_done = 1'b0;
    @(negedge PCLK);
    check("rst_accept", req_ready, 2'b10);
    for (int r = 1; r <= 3; r++) begin
      @(posedge PCLK); #1;
      req_valid = '0;
      @(negedge PCLK);
      check("rst_pre_xfer", m_transfer, r == 1);
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    PRESETn         = 1'b1;
    m_transfer_done = 1'b1;
    m_rdata         = DW'($urandom);
    @(negedge PCLK);
    check_quiet("midrst");
    check("midrst_rdata", rsp_rdata, '0);
    check("midrst_err", rsp_err, 1'b0);
    for (int r = 0; r < 20; r++) begin
      @(posedge PCLK); #1;
      m_transfer_done = 1'($urandom);
      @(negedge PCLK);
      check("midrst_no_rsp", rsp_valid, '0);
    end
    model_ptr = 0;
    randomize_reqs();
    run_txn(2'b11, 0, 1'b0, 1'b0, DW'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Round-robin request scheduler that shares the single APB master controller between `NREQ` on-chip requesters, such as the AES register client and the UART configuration client. It accepts one request at a time and drives the master's transaction inputs (`addr`, `transfer`, `write`, `byte_strobe`, `wdata`). It recovers read data from the master's `rdata`/`transfer_done`, returns a per-requester response, and enforces a timeout.

## Interface
- `NREQ`, 2, number of requesters (2..8)
- `DATA_WIDTH`, 32, APB data width
- `ADDR_WIDTH`, 32, APB address width
- `NBYTES`, `DATA_WIDTH/8`, strobe width
- `TIMEOUT`, 16, maximum WAIT cycles before error (≥4)

Ports:
- `PCLK`  in  1  clock
- `PRESETn`  in  1  reset, synchronous, active-low
- `req_valid`  in  `NREQ`  request pending, one bit per requester; held until accepted
- `req_ready`  out  `NREQ`  one-cycle accept pulse to the granted requester
- `req_addr`  in  `NREQ`×`ADDR_WIDTH`  per-requester address
- `req_write`  in  `NREQ`  1 = write
- `req_strb`  in  `NREQ`×`NBYTES`  byte strobes
- `req_wdata`  in  `NREQ`×`DATA_WIDTH`  write data
- `rsp_valid`  out  `NREQ`  one-cycle completion pulse to the owning requester
- `rsp_rdata`  out  `DATA_WIDTH`  read data; 0 on writes and on errors
- `rsp_err`  out  1  timeout flag, qualified by `rsp_valid`
- `m_addr`, `m_write`, `m_byte_strobe`, `m_wdata`  out  to the master's `addr`, `write`, `byte_strobe`, `wdata`
- `m_transfer`  out  1  to the master's `transfer`
- `m_rdata`  in  `DATA_WIDTH`  from the master's `rdata`
- `m_transfer_done`  in  1  from the master's `transfer_done`

## Operation
- **States:** ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP.
- **ARB_IDLE:**
  - If any `req_valid` is set, pick the first set bit searching upward from `rr_ptr`, with wrap-around.
  - Latch that requester's addr/write/strb/wdata into the transaction registers and record the owner.
  - Pulse `req_ready[owner]` and go to ARB_ISSUE.
  - Otherwise stay in ARB_IDLE.
- **ARB_ISSUE:** assert `m_transfer` for exactly one cycle, clear `wait_cnt`, go to ARB_WAIT.
- **ARB_WAIT:**
  - `wait_cnt` increments every cycle.
  - `rd_shadow <= m_rdata` every cycle.
  - Ignore `m_transfer_done` while `wait_cnt < 2`; this masks stale PREADY values from the master's IDLE and SETUP phases.
  - On a qualified `m_transfer_done`:
    - `rsp_rdata <= write ? 0 : rd_shadow`, where `rd_shadow` holds data from the PREADY cycle.
    - `rsp_err <= 0`.
    - Go to ARB_RESP.
  - Else, if `wait_cnt == TIMEOUT-1`: `rsp_rdata <= 0`, `rsp_err <= 1`, go to ARB_RESP.
  - If done and timeout occur in the same cycle, done wins.
- **ARB_RESP:** pulse `rsp_valid[owner]`, set `rr_ptr <= (owner+1) mod NREQ`, go to ARB_IDLE.
- **Pointer wrap:** `rr_ptr` wraps at `NREQ-1 → 0`. Only a completed transaction advances it.
- **Stable master inputs:** `m_addr`/`m_write`/`m_byte_strobe`/`m_wdata` come straight from the transaction registers and stay stable from ARB_ISSUE through ARB_RESP. They are 0 in ARB_IDLE.
- **Requests during a transaction:** `req_valid` changes are ignored outside ARB_IDLE. A requester that drops `req_valid` before being accepted is simply not selected.
- **Reset values:** all outputs 0; state ARB_IDLE; `rr_ptr` 0; `rsp_rdata` 0.
- **Reset mid-transaction:** abandon the transaction and emit no `rsp_valid`. The master shares `PRESETn` and returns to IDLE as well.

## Timing
- Accept at cycle T: `req_ready` high in T, `m_transfer` high in T+1.
- Master phases: SETUP in T+2, ACCESS from T+3.
- Zero-wait slave (PREADY in T+3):
  - `m_transfer_done` high in T+4.
  - `rsp_valid`/`rsp_rdata` in T+5.
  - Arbiter back in ARB_IDLE in T+6, with the next accept in T+6.
- Each slave wait state adds one cycle.
- Throughput: one transaction per 6 cycles minimum.
- Timeout: `rsp_valid` asserts `TIMEOUT+1` cycles after `m_transfer`.
- Outputs are registered except `m_*`, which are driven from registers only, and `req_ready`/`m_transfer`, which are decoded from the state register.

## Structure
- `shared_pkg` gains:
  - `apb_arb_state_e` {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP}
  - `APB_ARB_DONE_MASK = 2`, the masked WAIT cycles.
- One sub-module: `apb_rr_pick`. It is purely combinational: inputs `req_valid` and `rr_ptr`; outputs `any` and `idx`. It implements the rotate, priority-encode, unrotate sequence.
- Remaining work: FSM, counters, and transaction/response registers in `apb_req_arbiter`, about 200 lines.

## Test plan
- Single read: req0 reads 0x10 and the slave returns 0xCAFEF00D with zero waits → `req_ready[0]` at T, `rsp_valid[0]` at T+5, `rsp_rdata`=0xCAFEF00D, `rsp_err`=0.
- Write with strobe: req1 writes 0xA5A5A5A5 to 0x24 with strb 4'b0011 → the master sees addr 0x24, write=1, strb 0011 through ACCESS; `rsp_rdata`=0.
- Fairness: req0 and req1 both held valid for 4 transactions → grant order 0,1,0,1; `rr_ptr` wraps 1→0.
- Timeout: the slave never asserts PREADY with `TIMEOUT`=16 → `rsp_valid[owner]` 17 cycles after `m_transfer`, `rsp_err`=1, `rsp_rdata`=0, next request accepted.
- Wait states plus stale done: PREADY is stuck high while the master is idle and the slave inserts 3 waits → no early completion, and `rsp_rdata` is captured from the real PREADY cycle at T+8.
- Reset mid-WAIT: `PRESETn` is low for 1 cycle → all outputs 0, no `rsp_valid`, and the next request is granted from `rr_ptr`=0.
